display_scanout: RTL and testbench
==================================

DISPLAY_SCANOUT -- requirements
Module: display_scanout

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- BPP, 1, bits per colour channel, legal 1..8
- HACT, 640, active pixels per line
- HFP, 16, horizontal front porch, in clocks
- HSW, 96, hsync width, in clocks
- HBP, 48, horizontal back porch, in clocks
- VACT, 480, active lines
- VFP, 10, vertical front porch, in lines
- VSW, 2, vsync width, in lines
- VBP, 33, vertical back porch, in lines
- HSPOL, 0, hsync asserted level
- VSPOL, 0, vsync asserted level
- XSCALE, 1, horizontal pixel replication, legal 1, 2, 4
- YSCALE, 1, line replication, legal 1, 2, 4
- RDLAT, 1, vram read latency in clocks, legal 1..3
- AW, 17, vram address width
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, pixel clock
- rst, in, 1, asynchronous active-high reset
- vram_raddr, out, AW, framebuffer read address
- vram_rdata, in, 3*BPP, pixel word {r,g,b}, r in the MSBs
- red, out, BPP, red channel
- grn, out, BPP, green channel
- blu, out, BPP, blue channel
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- active, out, 1, data enable
- frame, out, 1, one-clock start-of-vblank pulse

Function
REQ-003 HTOT = HACT+HFP+HSW+HBP; VTOT = VACT+VFP+VSW+VBP.
REQ-004 hcnt counts 0..HTOT-1 every clock and wraps to 0.
REQ-005 vcnt increments when hcnt wraps; vcnt wraps from VTOT-1 to 0.
REQ-006 Raw de = (hcnt<HACT) && (vcnt<VACT).
REQ-007 Raw hs is asserted for hcnt in [HACT+HFP, HACT+HFP+HSW).
REQ-008 Raw vs is asserted for vcnt in [VACT+VFP, VACT+VFP+VSW), for whole lines.
REQ-009 Raw fr = 1 only at hcnt==0 && vcnt==VACT.
REQ-010 Addressing is incremental; no multiplier is used.
- linebase resets to 0 when vcnt wraps.
- At hcnt==0, ptr loads linebase.
- During raw de, ptr increments after every XSCALE-th pixel of the line.
REQ-011 At the end of each active line, a line sub-counter ysub advances mod YSCALE; when ysub wraps, linebase += HACT/XSCALE.
REQ-012 Framebuffer pixel (x,y) therefore sits at address (y/YSCALE)*(HACT/XSCALE) + x/XSCALE; addresses are truncated to AW bits.
REQ-013 vram_raddr is registered: counter state in cycle N drives vram_raddr in cycle N+1.
- vram_raddr holds its last value while raw de is low.
REQ-014 vram_rdata for the address presented in cycle N+1 is valid in cycle N+1+RDLAT and is registered into red/grn/blu.
REQ-015 Total latency from counter state to all outputs is L = RDLAT+2 clocks.
REQ-016 Raw de, hs, vs and fr pass through an L-stage shift register so they stay cycle-aligned with colour.
REQ-017 red, grn and blu are forced to 0 whenever the delayed de is 0.
REQ-018 hsync = delayed hs XNOR HSPOL, i.e. hsync equals HSPOL when asserted.
REQ-019 vsync = delayed vs XNOR VSPOL, i.e. vsync equals VSPOL when asserted.
REQ-020 active = delayed de; frame = delayed fr.
REQ-021 Illegal parameter values (BPP, XSCALE, YSCALE, RDLAT out of range; HACT not divisible by XSCALE) stop elaboration with an error.

Reset
REQ-022 While rst is high:
- hcnt, vcnt, ptr, linebase, ysub, all pipeline stages and vram_raddr are 0.
- red, grn, blu, active and frame are 0.
- hsync = !HSPOL, vsync = !VSPOL.
REQ-023 Reset is asynchronous assert, synchronous release. After release, raster position (0,0) appears on the outputs L clocks later.
REQ-024 Reset asserted mid-frame abandons the frame immediately; no partial line resumes after release.

Verification
REQ-025 Small timing (HACT=8, HFP=2, HSW=3, HBP=3, VACT=4, VFP=1, VSW=2, VBP=1, RDLAT=1), vram_rdata = address: first active cycle at clock 3 after release; pixels 0..7 on red/grn/blu; hsync low for clocks 3+10..3+12 of each 16-clock line.
REQ-026 Same timing with XSCALE=2, YSCALE=2:
- vram_raddr sequence per line is 0,0,1,1,2,2,3,3.
- Lines 0 and 1 read base 0; lines 2 and 3 read base 4.
REQ-027 Default 640x480 parameters: exactly 800 clocks per line and 525 lines per frame; frame pulses exactly 420000 clocks apart; active high for 640x480 = 307200 clocks per frame.
REQ-028 RDLAT=3 with a bench RAM model of 3-clock latency: active, hsync and colour transitions are all displaced by exactly 5 clocks from raw counter events; no stale pixel appears at line edges.
REQ-029 Polarity: HSPOL=1, VSPOL=1 → sync idles 0 during and after reset and pulses high; colour is 0 in blanking even when vram_rdata = all-ones.
REQ-030 Mid-frame reset at vcnt=2, hcnt=5, held 3 clocks: outputs take reset values asynchronously; after release the next active run starts at address 0 and frame pulses after VACT*HTOT+L clocks.

Source files
------------

// File: rtl/display_scanout.sv
// Raster timing generator and framebuffer scan-out: walks the frame, fetches pixels from
// VRAM with incremental addressing, and delays sync/enable to line up with the returned colour.
module display_scanout #(
    parameter int BPP    = 1,
    parameter int HACT   = 640,
    parameter int HFP    = 16,
    parameter int HSW    = 96,
    parameter int HBP    = 48,
    parameter int VACT   = 480,
    parameter int VFP    = 10,
    parameter int VSW    = 2,
    parameter int VBP    = 33,
    parameter bit HSPOL  = 1'b0,
    parameter bit VSPOL  = 1'b0,
    parameter int XSCALE = 1,
    parameter int YSCALE = 1,
    parameter int RDLAT  = 1,
    parameter int AW     = 17
) (
    input  logic             clk,
    input  logic             rst,
    output logic [AW-1:0]    vram_raddr,
    input  logic [3*BPP-1:0] vram_rdata,
    output logic [BPP-1:0]   red,
    output logic [BPP-1:0]   grn,
    output logic [BPP-1:0]   blu,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             frame
);

    localparam int HTOT = HACT + HFP + HSW + HBP;
    localparam int VTOT = VACT + VFP + VSW + VBP;
    localparam int L    = RDLAT + 2;
    localparam int HW   = $clog2(HTOT + 1);
    localparam int VW   = $clog2(VTOT + 1);
    localparam int XW   = (XSCALE > 1) ? $clog2(XSCALE) : 1;
    localparam int YW   = (YSCALE > 1) ? $clog2(YSCALE) : 1;
    localparam logic [AW-1:0] LSTEP = AW'(HACT / XSCALE);

    generate
        if (BPP < 1 || BPP > 8) begin : g_bad_bpp
            $error("display_scanout: BPP must be 1..8");
        end
        if (XSCALE != 1 && XSCALE != 2 && XSCALE != 4) begin : g_bad_xscale
            $error("display_scanout: XSCALE must be 1, 2 or 4");
        end
        if (YSCALE != 1 && YSCALE != 2 && YSCALE != 4) begin : g_bad_yscale
            $error("display_scanout: YSCALE must be 1, 2 or 4");
        end
        if (RDLAT < 1 || RDLAT > 3) begin : g_bad_rdlat
            $error("display_scanout: RDLAT must be 1..3");
        end
        if ((HACT % XSCALE) != 0) begin : g_bad_hact
            $error("display_scanout: HACT must be divisible by XSCALE");
        end
    endgenerate

    logic [HW-1:0]    hcnt;
    logic [VW-1:0]    vcnt;
    logic [XW-1:0]    xsub;
    logic [YW-1:0]    ysub;
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    linebase;
    logic [L-1:0]     de_p, hs_p, vs_p, fr_p;
    logic [3*BPP-1:0] rgb_q;

    logic             h_wrap, v_wrap, line_end, x_step;
    logic             de_raw, hs_raw, vs_raw, fr_raw;
    logic [XW-1:0]    xsub_cur;
    logic [AW-1:0]    cur_addr;

    always_comb begin
        h_wrap   = (hcnt == HW'(HTOT - 1));
        v_wrap   = (vcnt == VW'(VTOT - 1));
        de_raw   = (hcnt < HW'(HACT)) && (vcnt < VW'(VACT));
        hs_raw   = (hcnt >= HW'(HACT + HFP)) && (hcnt < HW'(HACT + HFP + HSW));
        vs_raw   = (vcnt >= VW'(VACT + VFP)) && (vcnt < VW'(VACT + VFP + VSW));
        fr_raw   = (hcnt == '0) && (vcnt == VW'(VACT));
        line_end = de_raw && (hcnt == HW'(HACT - 1));
        // First pixel of a line reads linebase directly, so ptr is never needed a cycle early.
        cur_addr = (hcnt == '0) ? linebase : ptr;
        xsub_cur = (hcnt == '0) ? '0 : xsub;
        x_step   = (xsub_cur == XW'(XSCALE - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt     <= '0;
            vcnt     <= '0;
            xsub     <= '0;
            ysub     <= '0;
            ptr      <= '0;
            linebase <= '0;
        end else begin
            hcnt <= h_wrap ? '0 : hcnt + 1'b1;
            if (h_wrap) begin
                vcnt <= v_wrap ? '0 : vcnt + 1'b1;
            end
            if (de_raw) begin
                xsub <= x_step ? '0 : xsub_cur + 1'b1;
                ptr  <= x_step ? cur_addr + 1'b1 : cur_addr;
            end else begin
                xsub <= xsub_cur;
                ptr  <= cur_addr;
            end
            if (h_wrap && v_wrap) begin
                ysub     <= '0;
                linebase <= '0;
            end else if (line_end) begin
                if (ysub == YW'(YSCALE - 1)) begin
                    ysub     <= '0;
                    linebase <= linebase + LSTEP;
                end else begin
                    ysub <= ysub + 1'b1;
                end
            end
        end
    end

    // Control bits ride an L-deep shift register; colour is captured one stage before the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_p       <= '0;
            hs_p       <= '0;
            vs_p       <= '0;
            fr_p       <= '0;
            vram_raddr <= '0;
            rgb_q      <= '0;
        end else begin
            de_p <= {de_p[L-2:0], de_raw};
            hs_p <= {hs_p[L-2:0], hs_raw};
            vs_p <= {vs_p[L-2:0], vs_raw};
            fr_p <= {fr_p[L-2:0], fr_raw};
            if (de_raw) begin
                vram_raddr <= cur_addr;
            end
            rgb_q <= de_p[L-2] ? vram_rdata : '0;
        end
    end

    assign red    = rgb_q[3*BPP-1:2*BPP];
    assign grn    = rgb_q[2*BPP-1:BPP];
    assign blu    = rgb_q[BPP-1:0];
    assign hsync  = ~(hs_p[L-1] ^ HSPOL);
    assign vsync  = ~(vs_p[L-1] ^ VSPOL);
    assign active = de_p[L-1];
    assign frame  = fr_p[L-1];

endmodule

// File: tb/tb_display_scanout.sv
// Directed bench for display_scanout: a 16x8-clock raster checked cycle by cycle on two
// configurations (unscaled, RDLAT=1, low syncs; 2x2 scaled, RDLAT=3, high syncs).
module tb_display_scanout;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: unscaled, RDLAT=1, active-low syncs, RAM returns its address.
    logic [16:0] ra_a;
    logic [11:0] rd_a, ram_a_d;
    logic [3:0]  red_a, grn_a, blu_a;
    logic        hs_a, vs_a, act_a, fr_a;

    // Instance B: 2x2 scaling, RDLAT=3, active-high syncs, RAM returns F00|address.
    logic [16:0] ra_b;
    logic [11:0] rd_b, rb_d0, rb_d1, rb_d2;
    logic [3:0]  red_b, grn_b, blu_b;
    logic        hs_b, vs_b, act_b, fr_b;
    logic [16:0] ra_exp_b = '0;

    display_scanout #(
        .BPP(4), .HACT(8), .HFP(2), .HSW(3), .HBP(3),
        .VACT(4), .VFP(1), .VSW(2), .VBP(1),
        .HSPOL(1'b0), .VSPOL(1'b0), .XSCALE(1), .YSCALE(1), .RDLAT(1), .AW(17)
    ) dut_a (
        .clk(clk), .rst(rst), .vram_raddr(ra_a), .vram_rdata(rd_a),
        .red(red_a), .grn(grn_a), .blu(blu_a),
        .hsync(hs_a), .vsync(vs_a), .active(act_a), .frame(fr_a)
    );

    display_scanout #(
        .BPP(4), .HACT(8), .HFP(2), .HSW(3), .HBP(3),
        .VACT(4), .VFP(1), .VSW(2), .VBP(1),
        .HSPOL(1'b1), .VSPOL(1'b1), .XSCALE(2), .YSCALE(2), .RDLAT(3), .AW(17)
    ) dut_b (
        .clk(clk), .rst(rst), .vram_raddr(ra_b), .vram_rdata(rd_b),
        .red(red_b), .grn(grn_b), .blu(blu_b),
        .hsync(hs_b), .vsync(vs_b), .active(act_b), .frame(fr_b)
    );

    always @(posedge clk) ram_a_d <= ra_a[11:0];
    assign rd_a = ram_a_d;

    always @(posedge clk) begin
        rb_d0 <= ra_b[11:0];
        rb_d1 <= rb_d0;
        rb_d2 <= rb_d1;
    end
    assign rd_b = 12'hF00 | rb_d2;

    task automatic check(input string tag, input int cyc, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference raster: HTOT=16, VTOT=8; negative positions mean "before first counter state".
    task automatic raster(input int p, output logic de, output logic hs, output logic vs,
                          output logic fr, output int x, output int y);
        x  = (p < 0) ? 0 : p % 16;
        y  = (p < 0) ? 0 : (p / 16) % 8;
        de = (p >= 0) && (x < 8) && (y < 4);
        hs = (p >= 0) && (x >= 10) && (x < 13);
        vs = (p >= 0) && (y >= 5) && (y < 7);
        fr = (p >= 0) && (x == 0) && (y == 4);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_act_a"}, -1, act_a, 0);
        check({tag, "_hs_a"}, -1, hs_a, 1);
        check({tag, "_vs_a"}, -1, vs_a, 1);
        check({tag, "_fr_a"}, -1, fr_a, 0);
        check({tag, "_rgb_a"}, -1, {red_a, grn_a, blu_a}, 0);
        check({tag, "_ra_a"}, -1, ra_a, 0);
        check({tag, "_act_b"}, -1, act_b, 0);
        check({tag, "_hs_b"}, -1, hs_b, 0);
        check({tag, "_vs_b"}, -1, vs_b, 0);
        check({tag, "_fr_b"}, -1, fr_b, 0);
        check({tag, "_rgb_b"}, -1, {red_b, grn_b, blu_b}, 0);
        check({tag, "_ra_b"}, -1, ra_b, 0);
    endtask

    // Sample n cycles after a reset release; cycle i shows raster i-3 (A) and i-5 (B).
    task automatic run_check(input int n);
        logic de, hs, vs, fr;
        int x, y;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            raster(i - 3, de, hs, vs, fr, x, y);
            check("act_a", i, act_a, de);
            check("hs_a", i, hs_a, !hs);
            check("vs_a", i, vs_a, !vs);
            check("fr_a", i, fr_a, fr);
            check("rgb_a", i, {red_a, grn_a, blu_a}, de ? (y * 8 + x) : 0);

            raster(i - 5, de, hs, vs, fr, x, y);
            check("act_b", i, act_b, de);
            check("hs_b", i, hs_b, hs);
            check("vs_b", i, vs_b, vs);
            check("fr_b", i, fr_b, fr);
            check("rgb_b", i, {red_b, grn_b, blu_b}, de ? (32'hF00 | ((y / 2) * 4 + x / 2)) : 0);

            raster(i - 1, de, hs, vs, fr, x, y);
            if (de) ra_exp_b = 17'((y / 2) * 4 + x / 2);
            check("ra_b", i, ra_b, ra_exp_b);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst      = 1'b0;
        ra_exp_b = '0;
        // Two whole frames plus 37 clocks leaves the counters at line 2, pixel 5.
        run_check(2 * 128 + 37);

        #2 rst = 1'b1;
        #1 check_idle("async_rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("held_rst");
        rst      = 1'b0;
        ra_exp_b = '0;
        run_check(80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
